// File: rtl/cpu_step_ctrl.sv
// ============================================================================
// Module   : cpu_step_ctrl
// Purpose  : Run / pause / single-step clock-enable controller for a soft CPU.
//            Optional button debounce is enabled by defining STEP_DEBOUNCE_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_step_ctrl #(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned DB_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_i,
   input  logic             run_sw_i,
   input  logic             step_btn_i,
   input  logic             clr_cnt_i,
   output logic             cpu_en_o,
   output logic [1:0]       mode_o,
   output logic [CNT_W-1:0] cycle_cnt_o
);

   typedef enum logic [1:0] {
      ST_PAUSE = 2'b00,
      ST_RUN   = 2'b01,
      ST_STEP  = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic             run_meta_q, run_s_q;
   logic             btn_meta_q, btn_s_q;
   logic             btn_db;
   logic             btn_db_prev_q;
   logic             step_req;
   logic             cpu_en_q, cpu_en_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_meta_q <= 1'b0;
         run_s_q    <= 1'b0;
         btn_meta_q <= 1'b0;
         btn_s_q    <= 1'b0;
      end else begin
         run_meta_q <= run_sw_i;
         run_s_q    <= run_meta_q;
         btn_meta_q <= step_btn_i;
         btn_s_q    <= btn_meta_q;
      end
   end

`ifdef STEP_DEBOUNCE_EN
   localparam int unsigned     DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            btn_db_q, btn_db_d;

   // Counter only runs while the synchronized level disagrees with the accepted one.
   always_comb begin
      db_cnt_d = '0;
      btn_db_d = btn_db_q;
      if (btn_s_q != btn_db_q) begin
         if (db_cnt_q == DB_LAST) begin
            btn_db_d = btn_s_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt_q <= '0;
         btn_db_q <= 1'b0;
      end else begin
         db_cnt_q <= db_cnt_d;
         btn_db_q <= btn_db_d;
      end
   end

   assign btn_db = btn_db_q;
`else
   logic db_unused;
   assign db_unused = ^DB_CYCLES;
   assign btn_db    = btn_s_q;
`endif

   assign step_req = btn_db & ~btn_db_prev_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_PAUSE: begin
            if (run_s_q) begin
               state_d = ST_RUN;
            end else if (step_req) begin
               state_d = ST_STEP;
            end
         end
         ST_RUN: begin
            if (!run_s_q) begin
               state_d = ST_PAUSE;
            end
         end
         ST_STEP: begin
            if (tick_i) begin
               state_d = ST_PAUSE;
            end
         end
         default: state_d = ST_PAUSE;
      endcase
   end

   // State is sampled before its update, so a tick on the leaving edge still fires.
   always_comb begin
      cpu_en_d = tick_i & ((state_q == ST_RUN) | (state_q == ST_STEP));
      cnt_d    = cnt_q;
      if (clr_cnt_i) begin
         cnt_d = '0;
      end else if (cpu_en_d) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_PAUSE;
         cpu_en_q      <= 1'b0;
         cnt_q         <= '0;
         btn_db_prev_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cpu_en_q      <= cpu_en_d;
         cnt_q         <= cnt_d;
         btn_db_prev_q <= btn_db;
      end
   end

   assign cpu_en_o    = cpu_en_q;
   assign mode_o      = state_q;
   assign cycle_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
// ============================================================================
// Module   : tb_cpu_step_ctrl
// Purpose  : Directed self-checking bench for cpu_step_ctrl (CNT_W=4, DB_CYCLES=4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_step_ctrl;

   localparam int CNT_W     = 4;
   localparam int DB_CYCLES = 4;
`ifdef STEP_DEBOUNCE_EN
   localparam int BTN_LAT   = 7;
`else
   localparam int BTN_LAT   = 3;
`endif
   localparam logic [1:0] M_PAUSE = 2'b00;
   localparam logic [1:0] M_RUN   = 2'b01;
   localparam logic [1:0] M_STEP  = 2'b10;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             tick_i, run_sw_i, step_btn_i, clr_cnt_i;
   logic             cpu_en_o;
   logic [1:0]       mode_o;
   logic [CNT_W-1:0] cycle_cnt_o;

   int n_tests  = 0;
   int n_failed = 0;
   int en_cnt   = 0;
   int en_base  = 0;
   int step_seen = 0;

   cpu_step_ctrl #(
      .CNT_W     (CNT_W),
      .DB_CYCLES (DB_CYCLES)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick_i      (tick_i),
      .run_sw_i    (run_sw_i),
      .step_btn_i  (step_btn_i),
      .clr_cnt_i   (clr_cnt_i),
      .cpu_en_o    (cpu_en_o),
      .mode_o      (mode_o),
      .cycle_cnt_o (cycle_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // One clock cycle with the given tick value; observe 1 ns after the edge.
   task automatic clk1(input logic t);
      tick_i = t;
      @(posedge clk);
      #1;
      tick_i = 1'b0;
      if (cpu_en_o) en_cnt++;
      if (mode_o == M_STEP) step_seen++;
   endtask

   initial begin
      rst_n      = 1'b0;
      tick_i     = 1'b0;
      run_sw_i   = 1'b0;
      step_btn_i = 1'b0;
      clr_cnt_i  = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_val("rst_mode", int'(mode_o), 0);
      check_val("rst_en", int'(cpu_en_o), 0);
      check_val("rst_cnt", int'(cycle_cnt_o), 0);
      rst_n = 1'b1;

      // Single step from PAUSE
      step_btn_i = 1'b1;
      for (int i = 0; i < BTN_LAT - 1; i++) clk1(1'b0);
      check_val("step_not_yet", int'(mode_o), int'(M_PAUSE));
      clk1(1'b0);
      check_val("step_enter", int'(mode_o), int'(M_STEP));
      for (int i = 0; i < 10 - BTN_LAT; i++) clk1(1'b0);
      step_btn_i = 1'b0;
      check_val("step_wait_tick", int'(mode_o), int'(M_STEP));
      check_val("step_no_en_early", en_cnt, 0);
      clk1(1'b1);
      check_val("step_en", int'(cpu_en_o), 1);
      check_val("step_exit", int'(mode_o), int'(M_PAUSE));
      check_val("step_cnt", int'(cycle_cnt_o), 1);
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 7; i++) clk1(1'b0);
         clk1(1'b1);
      end
      check_val("pause_ticks_en", en_cnt, 1);
      check_val("pause_mode", int'(mode_o), int'(M_PAUSE));

      // Free run, with a tick landing on the RUN->PAUSE edge
      run_sw_i = 1'b1;
      clk1(1'b0);
      clk1(1'b0);
      check_val("run_not_yet", int'(mode_o), int'(M_PAUSE));
      clk1(1'b0);
      check_val("run_enter", int'(mode_o), int'(M_RUN));
      clr_cnt_i = 1'b1;
      clk1(1'b0);
      clr_cnt_i = 1'b0;
      check_val("clr_cnt", int'(cycle_cnt_o), 0);
      for (int k = 0; k < 4; k++) begin
         clk1(1'b1);
         check_val("run_en_hi", int'(cpu_en_o), 1);
         clk1(1'b0);
         check_val("run_en_lo", int'(cpu_en_o), 0);
      end
      run_sw_i = 1'b0;
      clk1(1'b0);
      clk1(1'b0);
      check_val("run_still", int'(mode_o), int'(M_RUN));
      clk1(1'b1);
      check_val("edge_tick_en", int'(cpu_en_o), 1);
      check_val("edge_tick_mode", int'(mode_o), int'(M_PAUSE));
      check_val("run_cnt5", int'(cycle_cnt_o), 5);
      clk1(1'b1);
      check_val("pause_tick_no_en", int'(cpu_en_o), 0);

      // Button press during RUN is discarded
      run_sw_i = 1'b1;
      for (int i = 0; i < 3; i++) clk1(1'b0);
      step_btn_i = 1'b1;
      for (int i = 0; i < BTN_LAT + 3; i++) clk1(1'b0);
      check_val("run_btn_mode", int'(mode_o), int'(M_RUN));
      run_sw_i = 1'b0;
      step_seen = 0;
      for (int i = 0; i < 8; i++) clk1(1'b0);
      step_btn_i = 1'b0;
      for (int i = 0; i < 12; i++) clk1(1'b0);
      check_val("run_btn_pause", int'(mode_o), int'(M_PAUSE));
      check_val("run_btn_nostep", step_seen, 0);
      check_val("run_btn_cnt", int'(cycle_cnt_o), 5);

`ifdef STEP_DEBOUNCE_EN
      // Short glitch rejected, longer press accepted
      step_seen  = 0;
      step_btn_i = 1'b1;
      for (int i = 0; i < 3; i++) clk1(1'b0);
      step_btn_i = 1'b0;
      for (int i = 0; i < 12; i++) clk1(1'b0);
      check_val("glitch_nostep", step_seen, 0);
      step_btn_i = 1'b1;
      for (int i = 0; i < 6; i++) clk1(1'b0);
      step_btn_i = 1'b0;
      clk1(1'b0);
      check_val("held6_step", int'(mode_o), int'(M_STEP));
      for (int i = 0; i < 3; i++) clk1(1'b0);
      clk1(1'b1);
      check_val("held6_en", int'(cpu_en_o), 1);
      check_val("held6_exit", int'(mode_o), int'(M_PAUSE));
      check_val("held6_cnt", int'(cycle_cnt_o), 6);
      for (int i = 0; i < 12; i++) clk1(1'b0);
`endif

      // Counter wrap and clear-beats-increment
      run_sw_i = 1'b1;
      for (int i = 0; i < 3; i++) clk1(1'b0);
      clr_cnt_i = 1'b1;
      clk1(1'b0);
      clr_cnt_i = 1'b0;
      for (int k = 0; k < 7; k++) begin
         clk1(1'b1);
         clk1(1'b0);
      end
      check_val("cnt7", int'(cycle_cnt_o), 7);
      clr_cnt_i = 1'b1;
      clk1(1'b1);
      clr_cnt_i = 1'b0;
      check_val("clr_vs_inc_en", int'(cpu_en_o), 1);
      check_val("clr_vs_inc_cnt", int'(cycle_cnt_o), 0);
      for (int k = 0; k < 15; k++) begin
         clk1(1'b1);
         clk1(1'b0);
      end
      check_val("cnt15", int'(cycle_cnt_o), 15);
      clk1(1'b1);
      check_val("wrap_cnt", int'(cycle_cnt_o), 0);
      clk1(1'b1);
      check_val("post_wrap_cnt", int'(cycle_cnt_o), 1);
      run_sw_i = 1'b0;
      for (int i = 0; i < 3; i++) clk1(1'b0);
      check_val("wrap_pause", int'(mode_o), int'(M_PAUSE));

      // Reset in the middle of a step
      step_btn_i = 1'b1;
      for (int i = 0; i < BTN_LAT; i++) clk1(1'b0);
      check_val("rst_step_enter", int'(mode_o), int'(M_STEP));
      step_btn_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_val("rst_async_mode", int'(mode_o), 0);
      check_val("rst_async_en", int'(cpu_en_o), 0);
      check_val("rst_async_cnt", int'(cycle_cnt_o), 0);
      tick_i = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      tick_i  = 1'b0;
      rst_n   = 1'b1;
      en_base = en_cnt;
      for (int k = 0; k < 3; k++) begin
         clk1(1'b1);
         clk1(1'b0);
         clk1(1'b0);
      end
      check_val("rst_no_en", en_cnt, en_base);
      check_val("rst_after_mode", int'(mode_o), int'(M_PAUSE));
      check_val("rst_after_cnt", int'(cycle_cnt_o), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule

`default_nettype wire
